biu_scratch_slave: RTL
======================

BIU_SCRATCH_SLAVE -- requirements
Module: biu_scratch_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bus data width and word width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'hc0002000: first byte address of the decoded window.
REQ-004 SHALL have parameter NUM_WORDS, default 16, power of two, 2..256: scratch memory depth in words.
REQ-005 SHALL have parameter READ_LATENCY, default 2, range 1..15: cycles from read request to read response.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-007 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port bus_address, inout, ADDR_WIDTH: shared bus address; never driven by this block.
REQ-009 SHALL have port bus_data, inout, DATA_WIDTH: shared bus data; driven by this block only in a read response cycle.
REQ-010 SHALL have port bus_control, inout, 2 bits: shared bus command/response; driven by this block only in a response cycle.

Function
REQ-011 SHALL treat bus_control == 2'b10 as a read request and 2'b01 as a write request, both valid for exactly one cycle. Any other value, including Z/X, SHALL be treated as idle.
REQ-012 SHALL decode a request as a hit when BASE_ADDR <= bus_address < BASE_ADDR + 4*NUM_WORDS. The word index SHALL be bus_address[log2(NUM_WORDS)+1:2]. Address bits [1:0] SHALL be ignored.
REQ-013 SHALL ignore miss requests completely: no state change and no bus drive.
REQ-014 SHALL implement the FSM states IDLE, RDWAIT and RESP.
REQ-015 SHALL sample requests only in IDLE. Requests arriving in RDWAIT or RESP SHALL be ignored, because a single transaction is outstanding.
REQ-016 Write hit sampled at edge N:
- the memory word SHALL update with bus_data at edge N;
- the FSM SHALL go to RESP;
- bus_control SHALL be 2'b11 for the one cycle after edge N;
- bus_data SHALL stay Z.
REQ-017 Read hit sampled at edge N:
- the addressed word SHALL be snapshotted into a response register at edge N;
- if READ_LATENCY == 1, the FSM SHALL go to RESP;
- otherwise it SHALL go to RDWAIT with a down-counter loaded to READ_LATENCY-1, moving to RESP when the counter reaches 0.
REQ-018 In the read RESP cycle, bus_data SHALL equal the snapshotted word and bus_control SHALL equal 2'b11. This cycle SHALL begin READ_LATENCY cycles after the request cycle.
REQ-019 From RESP the FSM SHALL return to IDLE after exactly one cycle. A request present in that RESP cycle SHALL be ignored. A request in the first IDLE cycle after RESP SHALL be accepted.
REQ-020 Outside RESP, the block SHALL drive bus_data and bus_control to Z, and bus_address SHALL always be Z.
REQ-021 A read immediately following a write to the same word SHALL return the newly written data.
REQ-022 The highest-address word (index NUM_WORDS-1) SHALL be accessible. The address BASE_ADDR + 4*NUM_WORDS SHALL be a miss, and index wrap-around SHALL never occur.

Reset
REQ-023 While n_rst is 0, the block SHALL:
- set the FSM to IDLE and clear the latency counter;
- clear the response register and all memory words to 0;
- release bus_data and bus_control to Z immediately, without waiting for a clock edge.
REQ-024 When reset is asserted mid-transaction (RDWAIT or RESP), that transaction SHALL be abandoned and no response SHALL be driven after reset release.

Verification
REQ-025 Write 32'hdeadbeef to BASE_ADDR+8, then read BASE_ADDR+8 -> write ack 2'b11 one cycle after the write request; read response 2'b11 with 32'hdeadbeef exactly 2 cycles after the read request.
REQ-026 Read BASE_ADDR+4*NUM_WORDS-4 after reset -> data 0. Read BASE_ADDR+4*NUM_WORDS -> bus_data and bus_control stay Z for 10 cycles.
REQ-027 Issue a second request during RDWAIT and during RESP -> both ignored, memory unchanged. A request in the first following IDLE cycle -> accepted.
REQ-028 Assert n_rst low in RDWAIT -> bus released in the same cycle, no response after release, and a read of the previously written word returns 0.
REQ-029 Set READ_LATENCY=1 and 5, write then read with address bits [1:0]=2'b11 -> same word accessed; read response at request+1 and request+5 cycles respectively.
REQ-030 Run a back-to-back write/read sweep of all NUM_WORDS words with data = index*32'h01010101 -> every readback matches, with no Z/X on bus_data in any response cycle.

Source files
------------

// File: rtl/biu_scratch_slave.sv
// biu_scratch_slave: scratch RAM slave on a shared tristate bus.
// It serves one transaction at a time and drives the bus only in its response cycle.
module biu_scratch_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'hc0002000,
  parameter int NUM_WORDS = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  inout  wire  [ADDR_WIDTH-1:0] bus_address,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  inout  wire  [1:0]            bus_control
);
  localparam int IW = $clog2(NUM_WORDS);
  localparam logic [ADDR_WIDTH:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI = LO + (ADDR_WIDTH+1)'(4 * NUM_WORDS);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RDWAIT = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
  logic                  hit, rd_req, wr_req;
  logic [IW-1:0]         idx;
  // Range compare is one bit wider so a window ending at the top of the address space cannot wrap
  assign hit    = ({1'b0, bus_address} >= LO) && ({1'b0, bus_address} < HI);
  assign idx    = bus_address[IW+1:2];
  assign rd_req = (state_q == IDLE) && hit && (bus_control == 2'b10);
  assign wr_req = (state_q == IDLE) && hit && (bus_control == 2'b01);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    mem_d   = mem_q;
    if (rd_req) begin
      rdata_d = mem_q[idx];
      rd_d    = 1'b1;
      state_d = (READ_LATENCY == 1) ? RESP : RDWAIT;
      cnt_d   = 4'(READ_LATENCY - 1);
    end else if (wr_req) begin
      mem_d[idx] = bus_data;
      rd_d       = 1'b0;
      state_d    = RESP;
    end else if (state_q == RDWAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? RESP : RDWAIT;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end
  assign bus_address = {ADDR_WIDTH{1'bz}};
  assign bus_control = (state_q == RESP) ? 2'b11 : 2'bzz;
  assign bus_data    = (state_q == RESP && rd_q) ? rdata_q : {DATA_WIDTH{1'bz}};
endmodule
